// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the core's data-memory port.
//   Stores into the 16-byte window at BASE_ADDR queue bytes (TXDATA, offset 0x0)
//   or clear the sticky overflow flag (STATUS, offset 0x4). Queued bytes are sent
//   as 8N1 frames on tx, LSB first. Loads return STATUS / LEVEL combinationally.
// Ports:
//   clk        core clock, rising-edge state updates
//   reset      asynchronous active-low reset
//   addr       data address (ALU result)
//   write_data store data
//   memwrite   store strobe for the current cycle
//   hit        address falls inside the window (combinational)
//   read_data  register read value, 0 when hit=0 (combinational)
//   tx         serial line, idles high
//   busy       a frame is being shifted out
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  output logic        hit,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_nx;
  logic [TICK_W-1:0]   tick_cnt, tick_cnt_nx;
  logic [2:0]          bit_idx, bit_idx_nx;
  logic [7:0]          shift, shift_nx;

  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count;
  logic                overflow;

  logic [3:0]          offset;
  logic                wr_en, push, push_ok, drop, pop, clr_ovf;
  logic                fifo_empty, fifo_full, tick_last;

  // Only bits [7:0] and bit 3 of the store data are meaningful.
  logic                unused_wd;
  assign unused_wd = ^write_data[31:8];

  assign hit        = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset     = addr[3:0];
  assign wr_en      = memwrite & hit;
  assign push       = wr_en && (offset == 4'h0);
  assign clr_ovf    = wr_en && (offset == 4'h4) && write_data[3];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign tick_last  = (tick_cnt == TICK_LAST);

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && !push_ok;

  always_comb begin
    state_nx    = state;
    tick_cnt_nx = tick_cnt + 1'b1;
    bit_idx_nx  = bit_idx;
    shift_nx    = shift;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        tick_cnt_nx = '0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_nx = fifo_mem[rd_ptr];
          state_nx = START;
        end
      end
      START: begin
        if (tick_last) begin
          tick_cnt_nx = '0;
          bit_idx_nx  = '0;
          state_nx    = DATA;
        end
      end
      DATA: begin
        if (tick_last) begin
          tick_cnt_nx = '0;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            shift_nx   = {1'b0, shift[7:1]};
          end
        end
      end
      STOP: begin
        if (tick_last) begin
          tick_cnt_nx = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_nx = fifo_mem[rd_ptr];
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_cnt_nx;
      bit_idx  <= bit_idx_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped push outranks a clear in the same cycle.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Payload storage carries no reset; it is only read after being written.
  always_ff @(posedge clk) begin
    shift <= shift_nx;
    if (push_ok) fifo_mem[wr_ptr] <= write_data[7:0];
  end

  always_comb begin
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    read_data = '0;
    if (hit) begin
      case (offset)
        4'h4:    read_data = {28'd0, overflow, busy, fifo_empty, fifo_full};
        4'h8:    read_data = 32'(count);
        default: read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and
// FIFO_DEPTH=4. Expected line levels are built from the 8N1 frame layout.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          CPB  = 4;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        hit;
  logic [31:0] read_data;
  logic        tx;
  logic        busy;

  int tests = 0;
  int fails = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .hit        (hit),
    .read_data  (read_data),
    .tx         (tx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Line level k cycles after the write edge for a frame that starts at k=1.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int pos;
    logic [9:0] fr;
    pos = (k - 1) % (10 * CPB);
    fr  = {1'b1, b, 1'b0};
    return fr[pos / CPB];
  endfunction

  task automatic read_reg(input logic [3:0] off, input string tag, input logic [31:0] exp);
    addr = BASE | {28'd0, off};
    #1;
    chk(tag, read_data, exp);
  endtask

  logic [7:0] byte_k;

  initial begin
    reset      = 1'b0;
    addr       = BASE;
    write_data = '0;
    memwrite   = 1'b0;

    // Reset state and address decode.
    tick();
    tick();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    read_reg(4'h4, "rst_status", 32'h0000_0002);
    read_reg(4'h8, "rst_level", 32'h0);
    read_reg(4'h0, "txdata_read", 32'h0);
    addr = BASE + 32'h4; #1;
    chk("hit_in", {31'd0, hit}, 32'd1);
    addr = 32'h2000_0004; #1;
    chk("hit_out", {31'd0, hit}, 32'd0);
    chk("rd_out", read_data, 32'h0);
    reset = 1'b1;
    tick();
    tick();

    // Single frame of 0xA5; upper store bits must be discarded.
    addr = BASE; write_data = 32'hFFFF_FFA5; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
    chk("a5_tx_e0", {31'd0, tx}, 32'd1);
    read_reg(4'h8, "a5_level", 32'd1);
    for (int k = 1; k <= 10 * CPB; k++) begin
      tick();
      chk("a5_tx", {31'd0, tx}, {31'd0, frame_bit(8'hA5, k)});
      chk("a5_busy", {31'd0, busy}, 32'd1);
    end
    tick();
    chk("a5_busy_end", {31'd0, busy}, 32'd0);
    chk("a5_tx_end", {31'd0, tx}, 32'd1);

    // Six back-to-back writes into a 4-deep FIFO: five fit, the sixth drops.
    addr = BASE;
    for (int i = 0; i < 6; i++) begin
      write_data = 32'(i + 1);
      memwrite   = 1'b1;
      tick();
      if (i == 0) chk("burst_tx_e0", {31'd0, tx}, 32'd1);
      else        chk("burst_tx", {31'd0, tx}, {31'd0, frame_bit(8'(1), i)});
    end
    memwrite = 1'b0;
    read_reg(4'h4, "burst_status", 32'h0000_000D);
    read_reg(4'h8, "burst_level", 32'd4);
    for (int k = 6; k <= 50 * CPB; k++) begin
      tick();
      byte_k = 8'((k - 1) / (10 * CPB) + 1);
      chk("burst_tx", {31'd0, tx}, {31'd0, frame_bit(byte_k, k)});
      chk("burst_busy", {31'd0, busy}, 32'd1);
    end
    tick();
    chk("burst_busy_end", {31'd0, busy}, 32'd0);
    read_reg(4'h4, "ovf_held", 32'h0000_000A);

    // Overflow clear: bit3=0 leaves it, bit3=1 clears it.
    addr = BASE + 32'h4; write_data = 32'h0000_0000; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
    read_reg(4'h4, "ovf_keep", 32'h0000_000A);
    addr = BASE + 32'h4; write_data = 32'h0000_0008; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
    read_reg(4'h4, "ovf_clr", 32'h0000_0002);
    addr = BASE + 32'h4; write_data = 32'h0000_0000; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
    read_reg(4'h4, "ovf_stay", 32'h0000_0002);

    // Reset during DATA bit 3 with two bytes still queued.
    addr = BASE; memwrite = 1'b1;
    write_data = 32'h00; tick();
    write_data = 32'h11; tick();
    write_data = 32'h22; tick();
    memwrite = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("mid_tx_low", {31'd0, tx}, 32'd0);
    read_reg(4'h8, "mid_level", 32'd2);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_tx", {31'd0, tx}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    read_reg(4'h8, "arst_level", 32'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("post_rst_tx", {31'd0, tx}, 32'd1);
    end
    read_reg(4'h8, "post_rst_level", 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Store outside the window is ignored.
    addr = BASE + 32'h20; write_data = 32'h55; memwrite = 1'b1;
    #1;
    chk("miss_hit", {31'd0, hit}, 32'd0);
    chk("miss_rd", read_data, 32'h0);
    tick();
    memwrite = 1'b0;
    read_reg(4'h8, "miss_level", 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("miss_tx", {31'd0, tx}, 32'd1);
      chk("miss_busy", {31'd0, busy}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that acts as a responder on the single-cycle core's data-memory port. Store cycles are decoded against a 16-byte window, and each byte written to TXDATA is queued in a small FIFO. The block then serialises the bytes as 8N1 frames on `tx`. Load cycles to the window return status combinationally, so the top-level read mux can select `read_data` within the same cycle.

## Interface
- `BASE_ADDR`, 32'h1000_0000: window base; bits [3:0] are ignored.
- `CLKS_PER_BIT`, 16: clock cycles per UART bit (≥2).
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of 2, ≥2.

- `clk`  in  1  core clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `addr`  in  32  data address (core ALU result).
- `write_data`  in  32  store data.
- `memwrite`  in  1  store strobe for the current cycle.
- `hit`  out  1  `addr[31:4] == BASE_ADDR[31:4]`; combinational.
- `read_data`  out  32  register read value; combinational, 0 when `hit`=0.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  1 while a frame is being shifted out.

## Operation
- Register map (offset = `addr[3:0]`):
  - 0x0 TXDATA, write-only. Reads return 0.
  - 0x4 STATUS. bit0 = full, bit1 = empty, bit2 = busy, bit3 = overflow (sticky). Other bits read 0. Writing with `write_data[3]`=1 clears overflow; other bits are ignored.
  - 0x8 LEVEL, read-only. Returns the FIFO count, zero-extended.
  - Other offsets read 0, and writes to them are ignored.
- Writes take effect only when `memwrite`=1 and `hit`=1. A push stores `write_data[7:0]`; upper bits are discarded.
- Push acceptance:
  - A push is accepted when count < `FIFO_DEPTH`, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- FIFO uses circular read/write pointers with wrap-around at `FIFO_DEPTH`. Count width is `$clog2(FIFO_DEPTH)+1`.
- FSM states are IDLE, START, DATA, STOP. A bit counter (0..`CLKS_PER_BIT`-1) and a bit index (0..7) advance each state.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx` = shift[0], LSB first. Each bit lasts `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On its last cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- `busy` = (state ≠ IDLE).

## Timing
- Reset (async assert, `reset`=0):
  - `tx`=1, `busy`=0, FIFO empty, pointers 0, overflow 0, state IDLE.
  - `read_data` of STATUS = 0x0000_0002.
- Reads are zero-latency and combinational from `addr` and current state. A read sees state from before the current edge's write.
- Start-bit latency: a write at edge E into an empty, idle block is popped at edge E+1. `tx` falls at E+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit cycle.
- Simultaneous STATUS overflow-clear and a dropped push in the same cycle: overflow ends at 1 (set wins).
- Reset mid-frame: `tx` returns to 1 immediately. Queued bytes are discarded, and no partial frame resumes after release.
- Push and pop in the same cycle: count is unchanged and both pointers advance.

## Test plan
- Reset → `tx`=1, `busy`=0, STATUS reads 0x02, LEVEL reads 0. `hit` tracks `addr` with no clock.
- `CLKS_PER_BIT`=4, write 0xA5 to BASE+0x0 at edge E:
  - `tx`=0 over E+1..E+4.
  - Data bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Stop bit 1, then `busy`=0 at E+41.
- `FIFO_DEPTH`=4, six consecutive writes 0x01..0x06 at E..E+5:
  - Writes 1–5 are accepted (first pop at E+1); write 6 is dropped.
  - STATUS reads full=1, overflow=1.
  - Five frames 0x01..0x05 are sent with no idle gaps (200 cycles total).
- After overflow, write 0x08 to BASE+0x4 → STATUS bit3=0. Then write 0x00 to BASE+0x4 → no change.
- Assert reset during DATA bit 3 with 2 bytes queued:
  - `tx`=1 immediately.
  - After release, LEVEL=0 and `tx` stays 1 for 100 cycles.
- `memwrite`=1 at BASE+0x20 → `hit`=0, `read_data`=0, LEVEL unchanged, `tx` idle.
